wdt_controller: RTL and testbench



---
 rtl/wdt_controller_pkg.sv | 34 +++
 rtl/wdt_bus_decode.sv | 56 +++++
 rtl/wdt_controller.sv | 143 ++++++++++++++
 tb/tb_wdt_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wdt_controller_pkg.sv
// Shared constants for the watchdog timer: bus encodings, register map,
// kick key, FSM state encodings and the decoded-access strobe bundle.
package wdt_controller_pkg;

  // Bus geometry and access-size encodings shared with the other femto slaves
  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Register map
  localparam int unsigned WDT_VA_WIDTH = 4;
  localparam logic [WDT_VA_WIDTH-1:0] WDT_CTRL_OFS  = 4'd0;
  localparam logic [WDT_VA_WIDTH-1:0] WDT_LOAD_OFS  = 4'd4;
  localparam logic [WDT_VA_WIDTH-1:0] WDT_KICK_OFS  = 4'd8;
  localparam logic [WDT_VA_WIDTH-1:0] WDT_COUNT_OFS = 4'd12;

  localparam logic [7:0]           WDT_KICK_KEY = 8'h5A;
  localparam logic [BUS_WIDTH-1:0] WDT_LOAD_RST = 32'hFFFF_FFFF;

  // FSM state encodings
  localparam logic [1:0] WDT_ST_IDLE   = 2'd0;
  localparam logic [1:0] WDT_ST_RUN    = 2'd1;
  localparam logic [1:0] WDT_ST_EXPIRE = 2'd2;

  // One-hot per-access strobes from the decoder; all zero when req is low
  typedef struct packed {
    logic ctrl_wr;
    logic load_wr;
    logic kick_wr;
    logic rd;
  } wdt_strb_t;

endpackage

// File: rtl/wdt_bus_decode.sv
// Combinational validator for watchdog bus accesses.
// Ports:
//   addr/w_rb/acc/wdata/req : bus request fields
//   lock                    : current LOCK bit (blocks CTRL/LOAD writes)
//   invld                   : request is illegal (req qualified)
//   strb_c                  : per-register write strobes and read strobe
module wdt_bus_decode
  import wdt_controller_pkg::*;
(
  input  logic [WDT_VA_WIDTH-1:0]  addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  input  logic                     lock,
  output logic                     invld,
  output wdt_strb_t                strb_c
);

  logic      bad;
  wdt_strb_t hit;

  // Classify the access independently of req; req gates the outputs below
  always_comb begin
    bad = 1'b0;
    hit = '0;
    case (addr)
      WDT_CTRL_OFS: begin
        if (acc != BUS_ACC_1B)                    bad = 1'b1;
        else if (!w_rb)                           hit.rd = 1'b1;
        else if (lock || (wdata[7:2] != 6'd0))    bad = 1'b1;
        else                                      hit.ctrl_wr = 1'b1;
      end
      WDT_LOAD_OFS: begin
        if (acc != BUS_ACC_4B)                    bad = 1'b1;
        else if (!w_rb)                           hit.rd = 1'b1;
        else if (lock || (wdata == '0))           bad = 1'b1;
        else                                      hit.load_wr = 1'b1;
      end
      WDT_KICK_OFS: begin
        if (acc != BUS_ACC_1B || !w_rb)           bad = 1'b1;
        else if (wdata[7:0] != WDT_KICK_KEY)      bad = 1'b1;
        else                                      hit.kick_wr = 1'b1;
      end
      WDT_COUNT_OFS: begin
        if (acc != BUS_ACC_4B || w_rb)            bad = 1'b1;
        else                                      hit.rd = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  assign invld  = req & bad;
  assign strb_c = req ? hit : '0;

endmodule

// File: rtl/wdt_controller.sv
// Bus-attached watchdog: 32-bit down-counter that requests a low-active
// reset for HOLD_CYCLES cycles when software fails to kick it in time.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wdt_rst_b           : registered low-active reset request
//   addr/w_rb/acc/wdata : bus request fields, req qualifies them
//   resp/rdata          : registered one-cycle completion and read data
//   fault               : combinational illegal-access flag
module wdt_controller
  import wdt_controller_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     wdt_rst_b,
  input  logic [WDT_VA_WIDTH-1:0]  addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     rdata,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic                     resp,
  output logic                     fault
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [1:0]           state, state_nxt;
  logic [BUS_WIDTH-1:0] count, count_nxt;
  logic [BUS_WIDTH-1:0] load, load_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic                 en, en_nxt;
  logic                 lock, lock_nxt;
  logic                 resp_nxt;
  logic                 rst_b_nxt;
  logic [BUS_WIDTH-1:0] rdata_nxt;
  wdt_strb_t            strb_c;

  // Access validation and strobe generation
  wdt_bus_decode u_decode (
    .addr   (addr),
    .w_rb   (w_rb),
    .acc    (acc),
    .wdata  (wdata),
    .req    (req),
    .lock   (lock),
    .invld  (fault),
    .strb_c (strb_c)
  );

  // Next-state, register-update and output logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load_nxt  = load;
    hold_nxt  = hold_cnt;
    en_nxt    = en;
    lock_nxt  = lock;
    rdata_nxt = rdata;
    resp_nxt  = |strb_c;
    rst_b_nxt = 1'b1;

    if (strb_c.ctrl_wr) begin
      en_nxt   = wdata[0];
      lock_nxt = lock | wdata[1];
    end
    if (strb_c.load_wr) load_nxt = wdata;

    if (strb_c.rd) begin
      case (addr)
        WDT_CTRL_OFS: rdata_nxt = {30'd0, lock, en};
        WDT_LOAD_OFS: rdata_nxt = load;
        default:      rdata_nxt = count;
      endcase
    end

    case (state)
      WDT_ST_IDLE: begin
        if (strb_c.ctrl_wr && wdata[0]) begin
          state_nxt = WDT_ST_RUN;
          count_nxt = load;
        end
      end
      WDT_ST_RUN: begin
        // Disable freezes the count; a kick beats a simultaneous zero
        if (strb_c.ctrl_wr && !wdata[0]) begin
          state_nxt = WDT_ST_IDLE;
        end else if (strb_c.kick_wr) begin
          count_nxt = load;
        end else if (count == '0) begin
          state_nxt = WDT_ST_EXPIRE;
          hold_nxt  = HOLD_W'(HOLD_CYCLES - 1);
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      WDT_ST_EXPIRE: begin
        // Kicks are acknowledged but have no effect while holding reset
        if (hold_cnt == '0) begin
          count_nxt = load;
          if (lock) begin
            state_nxt = WDT_ST_RUN;
          end else begin
            state_nxt = WDT_ST_IDLE;
            en_nxt    = 1'b0;
          end
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_nxt = WDT_ST_IDLE;
    endcase

    rst_b_nxt = (state_nxt != WDT_ST_EXPIRE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WDT_ST_IDLE;
      count     <= WDT_LOAD_RST;
      load      <= WDT_LOAD_RST;
      hold_cnt  <= '0;
      en        <= 1'b0;
      lock      <= 1'b0;
      resp      <= 1'b0;
      rdata     <= '0;
      wdt_rst_b <= 1'b1;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      load      <= load_nxt;
      hold_cnt  <= hold_nxt;
      en        <= en_nxt;
      lock      <= lock_nxt;
      resp      <= resp_nxt;
      rdata     <= rdata_nxt;
      wdt_rst_b <= rst_b_nxt;
    end
  end

endmodule

// File: tb/tb_wdt_controller.sv
// Self-checking bench for wdt_controller: table-driven register/fault
// vectors followed by hand-written expiry, kick, lock and reset sequences.
module tb_wdt_controller;
  import wdt_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wdt_rst_b;
  logic [3:0]  addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        req;
  logic        resp;
  logic        fault;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rd;

  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        flt;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [20];

  wdt_controller #(.HOLD_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wdt_rst_b (wdt_rst_b),
    .addr      (addr),
    .w_rb      (w_rb),
    .acc       (acc),
    .rdata     (rdata),
    .wdata     (wdata),
    .req       (req),
    .resp      (resp),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus access; entered and left just after a falling edge
  task automatic bus_op(input logic t_w, input logic [3:0] t_a, input logic [1:0] t_sz,
                        input logic [31:0] t_d, input logic t_flt, input logic [31:0] t_rd,
                        input string name);
    req   = 1'b1;
    w_rb  = t_w;
    addr  = t_a;
    acc   = t_sz;
    wdata = t_d;
    #1;
    chk({name, " fault"}, {31'd0, fault}, {31'd0, t_flt});
    @(posedge clk);
    @(negedge clk);
    req   = 1'b0;
    w_rb  = 1'b0;
    wdata = '0;
    chk({name, " resp"}, {31'd0, resp}, {31'd0, !t_flt});
    if (!t_w && !t_flt) last_rd = t_rd;
    chk({name, " rdata"}, rdata, last_rd);
  endtask

  task automatic wr(input logic [3:0] t_a, input logic [1:0] t_sz, input logic [31:0] t_d,
                    input logic t_flt, input string name);
    bus_op(1'b1, t_a, t_sz, t_d, t_flt, 32'd0, name);
  endtask

  task automatic rd(input logic [3:0] t_a, input logic [1:0] t_sz, input logic [31:0] t_rd,
                    input string name);
    bus_op(1'b0, t_a, t_sz, 32'd0, 1'b0, t_rd, name);
  endtask

  task automatic chk_rstb(input logic exp, input string name);
    chk(name, {31'd0, wdt_rst_b}, {31'd0, exp});
  endtask

  // Advance n cycles, checking wdt_rst_b after each rising edge
  task automatic steps(input int n, input logic exp, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_rstb(exp, name);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [1:0] sz,
                              input logic [31:0] d, input logic flt, input logic [31:0] r);
    vec_t v;
    v.w = w; v.a = a; v.sz = sz; v.d = d; v.flt = flt; v.rd = r;
    return v;
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; w_rb = 1'b0; addr = '0; acc = '0; wdata = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rstb(1'b1, "reset wdt_rst_b");
    chk("reset resp", {31'd0, resp}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst = 1'b0;

    // Register map, reset values and illegal accesses from IDLE
    vecs[0]  = mk(1'b0, 4'd0,  BUS_ACC_1B, 32'd0,  1'b0, 32'h0000_0000);
    vecs[1]  = mk(1'b0, 4'd4,  BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);
    vecs[2]  = mk(1'b0, 4'd12, BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);
    vecs[3]  = mk(1'b1, 4'd8,  BUS_ACC_1B, 32'h33, 1'b1, 32'd0);
    vecs[4]  = mk(1'b1, 4'd0,  BUS_ACC_4B, 32'h1,  1'b1, 32'd0);
    vecs[5]  = mk(1'b1, 4'd4,  BUS_ACC_4B, 32'h0,  1'b1, 32'd0);
    vecs[6]  = mk(1'b0, 4'd8,  BUS_ACC_1B, 32'd0,  1'b1, 32'd0);
    vecs[7]  = mk(1'b1, 4'd6,  BUS_ACC_4B, 32'h7,  1'b1, 32'd0);
    vecs[8]  = mk(1'b1, 4'd12, BUS_ACC_4B, 32'h5,  1'b1, 32'd0);
    vecs[9]  = mk(1'b1, 4'd0,  BUS_ACC_1B, 32'h4,  1'b1, 32'd0);
    vecs[10] = mk(1'b0, 4'd4,  BUS_ACC_1B, 32'd0,  1'b1, 32'd0);
    vecs[11] = mk(1'b0, 4'd15, BUS_ACC_4B, 32'd0,  1'b1, 32'd0);
    vecs[12] = mk(1'b0, 4'd0,  BUS_ACC_1B, 32'd0,  1'b0, 32'h0000_0000);
    vecs[13] = mk(1'b0, 4'd4,  BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);
    vecs[14] = mk(1'b0, 4'd12, BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);
    vecs[15] = mk(1'b1, 4'd8,  BUS_ACC_1B, 32'h5A, 1'b0, 32'd0);
    vecs[16] = mk(1'b0, 4'd12, BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);
    vecs[17] = mk(1'b1, 4'd4,  BUS_ACC_4B, 32'd10, 1'b0, 32'd0);
    vecs[18] = mk(1'b0, 4'd4,  BUS_ACC_4B, 32'd0,  1'b0, 32'd10);
    vecs[19] = mk(1'b0, 4'd12, BUS_ACC_4B, 32'd0,  1'b0, 32'hFFFF_FFFF);

    for (int i = 0; i < 20; i++) begin
      bus_op(vecs[i].w, vecs[i].a, vecs[i].sz, vecs[i].d, vecs[i].flt, vecs[i].rd,
             $sformatf("vec%0d", i));
      chk_rstb(1'b1, $sformatf("vec%0d wdt_rst_b", i));
    end

    // Unlocked expiry: low on edges 11..26 after the enable edge, then IDLE
    wr(4'd0, BUS_ACC_1B, 32'h1, 1'b0, "exp en");
    steps(10, 1'b1, "exp pre");
    steps(16, 1'b0, "exp hold");
    steps(1, 1'b1, "exp release");
    rd(4'd0, BUS_ACC_1B, 32'h0, "exp ctrl after");
    rd(4'd12, BUS_ACC_4B, 32'd10, "exp count reloaded");
    steps(20, 1'b1, "exp idle");

    // Periodic kicks keep the counter alive
    wr(4'd0, BUS_ACC_1B, 32'h1, 1'b0, "kick en");
    for (int k = 0; k < 12; k++) begin
      steps(7, 1'b1, "kick run");
      wr(4'd8, BUS_ACC_1B, 32'h5A, 1'b0, "kick");
    end
    // Kick lands in the cycle COUNT is 0
    steps(10, 1'b1, "kick boundary pre");
    wr(4'd8, BUS_ACC_1B, 32'h5A, 1'b0, "kick at zero");
    chk_rstb(1'b1, "kick at zero rst_b");
    rd(4'd12, BUS_ACC_4B, 32'd10, "kick at zero count");
    // Disable while running freezes COUNT
    wr(4'd0, BUS_ACC_1B, 32'h0, 1'b0, "disable");
    rd(4'd12, BUS_ACC_4B, 32'd9, "frozen count");
    steps(15, 1'b1, "frozen idle");
    rd(4'd12, BUS_ACC_4B, 32'd9, "frozen count later");

    // Locked operation: CTRL/LOAD writes fault, expiry auto-restarts RUN
    wr(4'd0, BUS_ACC_1B, 32'h3, 1'b0, "lock en");
    wr(4'd0, BUS_ACC_1B, 32'h0, 1'b1, "lock ctrl wr");
    wr(4'd4, BUS_ACC_4B, 32'd5, 1'b1, "lock load wr");
    rd(4'd0, BUS_ACC_1B, 32'h3, "lock ctrl rd");
    steps(7, 1'b1, "lock pre");
    steps(5, 1'b0, "lock hold a");
    wr(4'd8, BUS_ACC_1B, 32'h5A, 1'b0, "kick in hold");
    chk_rstb(1'b0, "kick in hold rst_b");
    steps(10, 1'b0, "lock hold b");
    steps(1, 1'b1, "lock release");
    rd(4'd12, BUS_ACC_4B, 32'd10, "lock restart count");
    steps(9, 1'b1, "lock second pre");
    steps(1, 1'b0, "lock second fall");
    steps(3, 1'b0, "lock second hold");

    // Reset sampled on hold cycle 5
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_rstb(1'b1, "mid-hold reset rst_b");
    chk("mid-hold reset rdata", rdata, 32'd0);
    chk("mid-hold reset resp", {31'd0, resp}, 32'd0);
    rst = 1'b0;
    last_rd = '0;
    rd(4'd0, BUS_ACC_1B, 32'h0, "post-reset ctrl");
    rd(4'd4, BUS_ACC_4B, 32'hFFFF_FFFF, "post-reset load");
    rd(4'd12, BUS_ACC_4B, 32'hFFFF_FFFF, "post-reset count");
    steps(20, 1'b1, "post-reset idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
